// File: rtl/qc_ldpc_sraa_encoder.sv
// Serial-input systematic QC-LDPC parity encoder: one shift-register-adder-accumulator lane per parity block-column.
// Each accepted info bit XORs every lane's current circulant row into its accumulator, then rotates that row.
module qc_ldpc_sraa_encoder #(
  parameter int CIRC  = 32,
  parameter int K_BLK = 2,
  parameter int P_BLK = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [K_BLK*P_BLK*CIRC-1:0]    g_rows,
  input  logic                           info_valid,
  input  logic                           info_bit,
  output logic                           info_ready,
  output logic [P_BLK*CIRC-1:0]          parity_vec,
  output logic                           busy,
  output logic                           done
);

  localparam int RW = $clog2(CIRC);
  localparam int BW = (K_BLK > 1) ? $clog2(K_BLK) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(CIRC - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(K_BLK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                            state_q, state_d;
  logic [K_BLK*P_BLK*CIRC-1:0]       g_q, g_d;
  logic [P_BLK-1:0][CIRC-1:0]        row_q, row_d;
  logic [P_BLK*CIRC-1:0]             parity_q, parity_d;
  logic [RW-1:0]                     row_cnt_q, row_cnt_d;
  logic [BW-1:0]                     blk_cnt_q, blk_cnt_d;
  logic [BW-1:0]                     blk_nxt;

  logic start_acc;
  logic accept;
  logic row_last;
  logic blk_last;

  assign start_acc = (state_q == S_IDLE) && start;
  assign accept    = (state_q == S_RUN) && info_valid;
  assign row_last  = (row_cnt_q == ROW_LAST);
  assign blk_last  = (blk_cnt_q == BLK_LAST);
  assign blk_nxt   = blk_cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (accept && row_last && blk_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    info_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_RUN: begin
        info_ready = 1'b1;
        busy       = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        info_ready = 1'b0;
      end
    endcase
  end

  // Datapath next-state: frame load on start, accumulate-and-rotate on accept.
  always_comb begin
    g_d       = g_q;
    row_d     = row_q;
    parity_d  = parity_q;
    row_cnt_d = row_cnt_q;
    blk_cnt_d = blk_cnt_q;

    if (start_acc) begin
      g_d       = g_rows;
      parity_d  = '0;
      row_cnt_d = '0;
      blk_cnt_d = '0;
      for (int j = 0; j < P_BLK; j++) begin
        row_d[j] = g_rows[j*CIRC +: CIRC];
      end
    end else if (accept) begin
      for (int j = 0; j < P_BLK; j++) begin
        parity_d[j*CIRC +: CIRC] = parity_q[j*CIRC +: CIRC] ^ ({CIRC{info_bit}} & row_q[j]);
        row_d[j] = {row_q[j][CIRC-2:0], row_q[j][CIRC-1]};
      end
      if (row_last) begin
        row_cnt_d = '0;
        if (!blk_last) begin
          blk_cnt_d = blk_nxt;
          // Next block-row is loaded on the same edge so the bit stream never bubbles.
          for (int b = 1; b < K_BLK; b++) begin
            if (blk_nxt == BW'(b)) begin
              for (int j = 0; j < P_BLK; j++) begin
                row_d[j] = g_q[(b*P_BLK + j)*CIRC +: CIRC];
              end
            end
          end
        end
      end else begin
        row_cnt_d = row_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_q       <= '0;
      row_q     <= '0;
      parity_q  <= '0;
      row_cnt_q <= '0;
      blk_cnt_q <= '0;
    end else begin
      g_q       <= g_d;
      row_q     <= row_d;
      parity_q  <= parity_d;
      row_cnt_q <= row_cnt_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign parity_vec = parity_q;

endmodule

// File: doc/qc_ldpc_sraa_encoder.md
Name: qc_ldpc_sraa_encoder

Overview:
- Parametrised serial-input systematic QC-LDPC parity encoder built on shift-register-adder-accumulator (SRAA) lanes.
- It is the generalised successor of the fixed 32-bit, single-parity-lane encoder datapath/control pair.
- It supports arbitrary circulant size, info block-row count and parity block-column count.
- It provides a valid/ready input handshake with stall tolerance, and an explicit busy/done status.
- It sits between the info-bit source and the codeword assembler, which appends parity_vec after the info bits.

Parameters:
- CIRC, 32: circulant size B (bits per circulant). Must be ≥2.
- K_BLK, 2: number of info block-rows. Info length is K_BLK*CIRC.
- P_BLK, 1: number of parity block-columns, i.e. parallel SRAA lanes. Parity length is P_BLK*CIRC.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin a frame. Sampled only in IDLE.
- g_rows  in  K_BLK*P_BLK*CIRC  first rows of the generator circulants. Circulant (i,j) occupies [(i*P_BLK+j)*CIRC +: CIRC]; bit c is column c. Captured on accepted start.
- info_valid  in  1  info_bit is valid.
- info_bit  in  1  serial info bit, in order u0, u1, … u(K_BLK*CIRC-1).
- info_ready  out  1  encoder accepts a bit this cycle.
- parity_vec  out  P_BLK*CIRC  parity accumulators. Lane j is at [j*CIRC +: CIRC].
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse when parity_vec is final.

Behaviour:
- Reset (async, any state): state=IDLE; all row registers, the captured-G register, parity_vec, and the row/block counters go to 0; info_ready=0, busy=0, done=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - info_ready=0.
  - On start: capture g_rows; clear parity_vec; row_cnt=0; blk_cnt=0; load each lane's row register with the first row of circulant (0,j); go to RUN.
- RUN:
  - info_ready=1 (combinational from state).
  - An accept is info_valid&&info_ready. Cycles with info_valid=0 change nothing.
  - On accept, for each lane j: parity_vec lane j ^= {CIRC{info_bit}} & rowreg_j, then rowreg_j rotates cyclically by one toward higher index (new[c]=old[(c-1) mod CIRC]).
  - As a result, circulant row r equals g[(c-r) mod CIRC].
  - If row_cnt==CIRC-1 on accept: row_cnt=0.
    - If blk_cnt==K_BLK-1: go to DONE.
    - Else: blk_cnt++ and reload rowreg_j from circulant (blk_cnt+1, j) in that same edge, with no bubble.
  - Otherwise on accept: row_cnt++.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE.
  - parity_vec is final during DONE and holds until the next accepted start or reset.
- Latency: done is asserted in the cycle immediately after the edge that accepts the last info bit. With no stalls a frame takes K_BLK*CIRC RUN cycles plus 1 DONE cycle.
- start is ignored in RUN and DONE, so it can never restart a frame mid-operation. The earliest next start is honoured in the first IDLE cycle.
- info_valid outside RUN is ignored; no bit is consumed.
- Changes to g_rows after the start capture have no effect on the frame in progress.
- Counter widths: row_cnt is $clog2(CIRC) bits; blk_cnt is max(1,$clog2(K_BLK)) bits. Both counters wrap only under FSM control.
- Reset mid-frame aborts immediately; the partial parity is discarded (zeroed).

Test Plan:
- Identity, CIRC=4 K_BLK=1 P_BLK=1: g_rows=4'b0001, info 1,0,1,1 with info_valid continuous -> parity_vec=4'b1101; done pulses 1 cycle after the 4th accept; busy falls the following cycle.
- Two lanes, CIRC=4 K_BLK=1 P_BLK=2: g_rows=8'b0010_0001, info 1,0,1,1 -> parity_vec=8'b1011_1101.
- Defaults, all-ones G: g_rows all ones, 64 info bits containing five 1s -> parity_vec=32'hFFFFFFFF. Repeat with six 1s -> 32'h00000000; parity_vec is cleared at the second start.
- Stalls: rerun the identity case with info_valid low for 3 cycles between every bit -> identical parity_vec=4'b1101; info_ready stays 1 throughout RUN; done occurs 1 cycle after the last accept.
- Start while busy: pulse start at bit 2 of a running frame -> ignored, result unchanged. A start in the DONE cycle is also ignored; a start in the next cycle launches a new frame.
- Reset mid-frame: defaults, assert rst after 10 accepted bits -> parity_vec=0, busy=0, info_ready=0, done=0 immediately (asynchronously). A subsequent full frame reproduces the all-ones-G result.
